// File: rtl/sseg_disp_arbiter_if.sv
// Display-sharing bus between the requesters and the seven-segment arbiter.
// The arbiter sits on the slave side; the requester side drives i_req/i_digits_n.
interface sseg_disp_arbiter_if #(
  parameter int N_REQ = 2
);
  logic [N_REQ-1:0]            i_req;
  logic [N_REQ-1:0][3:0][7:0]  i_digits_n;
  logic [N_REQ-1:0]            o_grant;
  logic [3:0][7:0]             o_digits_n;
  logic                        o_busy;

  modport master (output i_req, i_digits_n, input o_grant, o_digits_n, o_busy);
  modport slave  (input i_req, i_digits_n, output o_grant, o_digits_n, o_busy);
endinterface

// File: rtl/sseg_disp_arbiter.sv
// Round-robin owner of the 4-digit seven-segment display with a minimum hold
// time and an all-blank gap between owners, so digits never show half-replaced.
module sseg_disp_arbiter #(
  parameter int N_REQ       = 2,
  parameter int TICK_N      = 20,
  parameter int HOLD_TICKS  = 64,
  parameter int BLANK_TICKS = 8
) (
  input  logic               i_clk,
  input  logic               i_reset_n,
  sseg_disp_arbiter_if.slave bus
);
  localparam int PW = $clog2(N_REQ);

  typedef enum logic [1:0] {IDLE, OWN, GAP} state_t;

  state_t             state, state_nx;
  logic [TICK_N-1:0]  presc;
  logic               tick;
  logic [7:0]         hold_cnt, hold_nx, gap_cnt, gap_nx;
  logic [PW-1:0]      last, last_nx;
  logic [N_REQ-1:0]   grant_q, grant_nx, others;
  logic [3:0][7:0]    digits_q, digits_nx;
  logic               pick_vld, repick, repick_show;
  logic [PW-1:0]      pick_idx, cand;

  assign tick           = &presc;
  assign others         = bus.i_req & ~(N_REQ'(1) << last);
  assign bus.o_grant    = grant_q;
  assign bus.o_digits_n = digits_q;
  assign bus.o_busy     = (state != IDLE);

  // Search starts one past the previous owner, so the previous owner is
  // considered last and regains the display only if nobody else asks.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    cand     = last;
    for (int i = 0; i < N_REQ; i++) begin
      cand = (cand == PW'(N_REQ-1)) ? '0 : cand + 1'b1;
      if (!pick_vld && bus.i_req[cand]) begin
        pick_vld = 1'b1;
        pick_idx = cand;
      end
    end
  end

  always_comb begin
    state_nx    = state;
    last_nx     = last;
    hold_nx     = hold_cnt;
    gap_nx      = gap_cnt;
    grant_nx    = '0;
    digits_nx   = '1;
    repick      = 1'b0;
    repick_show = 1'b0;
    case (state)
      IDLE: begin
        repick      = pick_vld;
        repick_show = 1'b1;
      end
      OWN: begin
        if (tick && hold_cnt != 8'(HOLD_TICKS)) hold_nx = hold_cnt + 8'd1;
        // A drop wins over hold expiry; both exit identically anyway.
        if (!bus.i_req[last] || (hold_cnt == 8'(HOLD_TICKS) && |others)) begin
          if (BLANK_TICKS > 0) begin
            state_nx = GAP;
            gap_nx   = '0;
          end else begin
            // Grant withheld one cycle: that cycle is the single blank frame.
            repick = 1'b1;
          end
        end else begin
          grant_nx  = N_REQ'(1) << last;
          digits_nx = bus.i_digits_n[last];
        end
      end
      GAP: begin
        if (gap_cnt == 8'(BLANK_TICKS)) begin
          repick      = 1'b1;
          repick_show = 1'b1;
        end else if (tick) begin
          gap_nx = gap_cnt + 8'd1;
        end
      end
      default: state_nx = IDLE;
    endcase
    if (repick) begin
      if (pick_vld) begin
        state_nx = OWN;
        last_nx  = pick_idx;
        hold_nx  = '0;
        if (repick_show) grant_nx = N_REQ'(1) << pick_idx;
      end else begin
        state_nx = IDLE;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state    <= IDLE;
      presc    <= '0;
      hold_cnt <= '0;
      gap_cnt  <= '0;
      last     <= PW'(N_REQ-1);
      grant_q  <= '0;
      digits_q <= '1;
    end else begin
      state    <= state_nx;
      presc    <= presc + 1'b1;
      hold_cnt <= hold_nx;
      gap_cnt  <= gap_nx;
      last     <= last_nx;
      grant_q  <= grant_nx;
      digits_q <= digits_nx;
    end
  end
endmodule

// File: tb/tb_sseg_disp_arbiter.sv
// Directed bench for sseg_disp_arbiter: TICK_N=2, HOLD_TICKS=3, BLANK_TICKS=1, N_REQ=2.
// Edge counts are taken from reset release; hold/gap counters advance on edges 4,8,12,...
module tb_sseg_disp_arbiter;
  logic clk = 1'b0;
  logic rst_n;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc   = 0;

  logic [3:0][7:0] D0, D1, BLK;
  logic [34:0]     act_v, exp_v;
  logic [1:0]      e_gr;
  logic            e_busy;
  logic [3:0][7:0] e_dig;
  int              m;

  sseg_disp_arbiter_if #(.N_REQ(2)) bus ();

  sseg_disp_arbiter #(
    .N_REQ(2), .TICK_N(2), .HOLD_TICKS(3), .BLANK_TICKS(1)
  ) dut (
    .i_clk     (clk),
    .i_reset_n (rst_n),
    .bus       (bus.slave)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step;
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic do_reset;
    @(negedge clk);
    rst_n = 1'b0;
    bus.i_req = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    cyc = 0;
  endtask

  task automatic test_reset;
    bus.i_req = '0;
    bus.i_digits_n = {D1, D0};
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if (bus.o_grant !== 2'b00) begin
      n_bad++; $display("FAIL reset_grant got=%b exp=00", bus.o_grant);
    end
    n_cmp++;
    if (bus.o_busy !== 1'b0) begin
      n_bad++; $display("FAIL reset_busy got=%b exp=0", bus.o_busy);
    end
    n_cmp++;
    if (bus.o_digits_n !== BLK) begin
      n_bad++; $display("FAIL reset_digits got=%h exp=%h", bus.o_digits_n, BLK);
    end
    rst_n = 1'b1;
    cyc = 0;
    for (int i = 0; i < 50; i++) begin
      step();
      act_v = {bus.o_grant, bus.o_busy, bus.o_digits_n};
      exp_v = {2'b00, 1'b0, BLK};
      n_cmp++;
      if (act_v !== exp_v) begin
        n_bad++; $display("FAIL idle_hold cyc=%0d got=%h exp=%h", cyc, act_v, exp_v);
      end
    end
  endtask

  task automatic test_single;
    do_reset();
    bus.i_req = 2'b01;
    step();
    act_v = {bus.o_grant, bus.o_busy, bus.o_digits_n};
    exp_v = {2'b01, 1'b1, BLK};
    n_cmp++;
    if (act_v !== exp_v) begin
      n_bad++; $display("FAIL single_grant cyc=%0d got=%h exp=%h", cyc, act_v, exp_v);
    end
    for (int i = 0; i < 200; i++) begin
      step();
      act_v = {bus.o_grant, bus.o_busy, bus.o_digits_n};
      exp_v = {2'b01, 1'b1, D0};
      n_cmp++;
      if (act_v !== exp_v) begin
        n_bad++; $display("FAIL single_hold cyc=%0d got=%h exp=%h", cyc, act_v, exp_v);
      end
    end
  endtask

  // req0 owns from edge 1, req1 joins after edge 2; hold expires at edge 12.
  task automatic test_contention;
    do_reset();
    bus.i_req = 2'b01;
    while (cyc < 32) begin
      step();
      if      (cyc <= 12) e_gr = 2'b01;
      else if (cyc <= 16) e_gr = 2'b00;
      else if (cyc <= 28) e_gr = 2'b10;
      else                e_gr = 2'b00;
      if      (cyc >= 2  && cyc <= 12) e_dig = D0;
      else if (cyc >= 18 && cyc <= 28) e_dig = D1;
      else                             e_dig = BLK;
      act_v = {bus.o_grant, bus.o_busy, bus.o_digits_n};
      exp_v = {e_gr, 1'b1, e_dig};
      n_cmp++;
      if (act_v !== exp_v) begin
        n_bad++; $display("FAIL contention cyc=%0d got=%h exp=%h", cyc, act_v, exp_v);
      end
      if (cyc == 2) bus.i_req = 2'b11;
    end
  endtask

  // Continues the contention timeline: 32-cycle period from edge 17.
  task automatic test_round_robin;
    while (cyc < 100) begin
      step();
      m = (cyc - 17) % 32;
      if      (m < 12) e_gr = 2'b10;
      else if (m < 16) e_gr = 2'b00;
      else if (m < 28) e_gr = 2'b01;
      else             e_gr = 2'b00;
      if      (m >= 1  && m <= 11) e_dig = D1;
      else if (m >= 17 && m <= 27) e_dig = D0;
      else                         e_dig = BLK;
      act_v = {bus.o_grant, bus.o_busy, bus.o_digits_n};
      exp_v = {e_gr, 1'b1, e_dig};
      n_cmp++;
      if (act_v !== exp_v) begin
        n_bad++; $display("FAIL round_robin cyc=%0d got=%h exp=%h", cyc, act_v, exp_v);
      end
    end
  endtask

  task automatic test_early_release;
    do_reset();
    bus.i_req = 2'b11;
    while (cyc < 14) begin
      step();
      e_busy = 1'b1;
      e_dig  = BLK;
      if (cyc <= 5) begin
        e_gr = 2'b01;
        if (cyc >= 2) e_dig = D0;
      end else if (cyc <= 8) begin
        e_gr = 2'b00;
      end else if (cyc <= 10) begin
        e_gr = 2'b10;
        if (cyc == 10) e_dig = D1;
      end else begin
        e_gr = 2'b00;
        if (cyc >= 13) e_busy = 1'b0;
      end
      act_v = {bus.o_grant, bus.o_busy, bus.o_digits_n};
      exp_v = {e_gr, e_busy, e_dig};
      n_cmp++;
      if (act_v !== exp_v) begin
        n_bad++; $display("FAIL early_release cyc=%0d got=%h exp=%h", cyc, act_v, exp_v);
      end
      if (cyc == 5)  bus.i_req = 2'b10;
      if (cyc == 10) bus.i_req = 2'b00;
    end
  endtask

  task automatic test_async_reset;
    do_reset();
    bus.i_req = 2'b11;
    repeat (20) step();
    n_cmp++;
    if (bus.o_grant !== 2'b10) begin
      n_bad++; $display("FAIL pre_async_grant got=%b exp=10", bus.o_grant);
    end
    #1 rst_n = 1'b0;
    #1;
    n_cmp++;
    if (bus.o_grant !== 2'b00) begin
      n_bad++; $display("FAIL async_grant got=%b exp=00", bus.o_grant);
    end
    n_cmp++;
    if (bus.o_digits_n !== BLK) begin
      n_bad++; $display("FAIL async_digits got=%h exp=%h", bus.o_digits_n, BLK);
    end
    n_cmp++;
    if (bus.o_busy !== 1'b0) begin
      n_bad++; $display("FAIL async_busy got=%b exp=0", bus.o_busy);
    end
    #1 rst_n = 1'b1;
    cyc = 0;
    step();
    n_cmp++;
    if (bus.o_grant !== 2'b01) begin
      n_bad++; $display("FAIL post_async_grant got=%b exp=01", bus.o_grant);
    end
    step();
    n_cmp++;
    if (bus.o_digits_n !== D0) begin
      n_bad++; $display("FAIL post_async_digits got=%h exp=%h", bus.o_digits_n, D0);
    end
  endtask

  initial begin
    D0  = {8'hC0, 8'hF9, 8'hA4, 8'hB0};
    D1  = {8'h99, 8'h92, 8'h82, 8'hF8};
    BLK = '1;
    rst_n = 1'b1;
    bus.i_req = '0;
    bus.i_digits_n = {D1, D0};
    test_reset();
    test_single();
    test_contention();
    test_round_robin();
    test_early_release();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
